// File: rtl/aes_inv_key_sched.sv
// AES-128 key scheduler that emits round keys from round 10 down to round 0.
// One 128-bit key register is kept; the schedule is walked forward, then undone one key per handshake.
module aes_inv_key_sched (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] keyin,
  output logic [127:0] key_out,
  output logic [3:0]   round_out,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Byte x of the forward S-box sits at bits [8*(255-x)+7 -: 8], i.e. {~x, 3'b111}.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] j);
    logic [7:0] rc;
    rc = 8'h00;
    case (j)
      4'd0: rc = 8'h01;
      4'd1: rc = 8'h02;
      4'd2: rc = 8'h04;
      4'd3: rc = 8'h08;
      4'd4: rc = 8'h10;
      4'd5: rc = 8'h20;
      4'd6: rc = 8'h40;
      4'd7: rc = 8'h80;
      4'd8: rc = 8'h1b;
      4'd9: rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_in, rot, sub_out, g;
  logic [3:0]  rc_idx;
  logic [31:0] f0, f1, f2, f3;
  logic [31:0] i0, i1, i2, i3;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // The single SubWord instance sees the live w3 going forward and the recovered w3 going back.
  assign sub_in  = (state_q == EMIT) ? (w3 ^ w2) : w3;
  assign rot     = {sub_in[23:0], sub_in[31:24]};
  assign sub_out = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign rc_idx  = (state_q == EMIT) ? (round_q - 4'd1) : cnt_q;
  assign g       = sub_out ^ {rcon(rc_idx), 24'h000000};

  assign f0 = w0 ^ g;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign i3 = w3 ^ w2;
  assign i2 = w2 ^ w1;
  assign i1 = w1 ^ w0;
  assign i0 = w0 ^ g;

  // Handshake: a key transfers on a rising edge where key_valid and key_ready are both high;
  // while key_valid is high and no transfer happens, key_out/round_out are held.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = keyin;
          cnt_d   = 4'd0;
          state_d = FWD;
        end
      end
      FWD: begin
        key_d = {f0, f1, f2, f3};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          round_d = 4'd10;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (key_ready) begin
          if (round_q != 4'd0) begin
            key_d   = {i0, i1, i2, i3};
            round_d = round_q - 4'd1;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign key_out   = key_q;
  assign round_out = round_q;
  assign key_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: FIPS-197 vectors, scoreboarded random keys under backpressure,
// start/reset interference and back-to-back jobs. The reference builds its S-box from GF(2^8).
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         reset, start, key_ready;
  logic [127:0] keyin, key_out;
  logic [3:0]   round_out;
  logic         key_valid, busy, done;
  logic [1:0]   state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [131:0] exp_q[$];
  logic [7:0]   sb_m [0:255];
  logic [127:0] rk_m [0:10];

  always #5 clk = ~clk;

  aes_inv_key_sched dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .keyin     (keyin),
    .key_out   (key_out),
    .round_out (round_out),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      b = inv;
      sb_m[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic compute_schedule(input logic [127:0] k);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    rk_m[0] = k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      {w0, w1, w2, w3} = rk_m[r-1];
      t  = {sb_m[w3[23:16]], sb_m[w3[15:8]], sb_m[w3[7:0]], sb_m[w3[31:24]]} ^ {rc, 24'h000000};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rk_m[r] = {w0, w1, w2, w3};
      rc = xtime(rc);
    end
  endtask

  // Starts one job at the current negedge and scoreboards it until the done cycle.
  task automatic run_job(input logic [127:0] k, input int ready_pct, input bit poke);
    int cyc;
    logic [131:0] e;
    compute_schedule(k);
    for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), rk_m[r]});
    keyin = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    keyin = {$urandom, $urandom, $urandom, $urandom};
    cyc = 1;
    while (exp_q.size() != 0 && cyc < 400) begin
      if (poke) start = 1'($urandom_range(1));
      key_ready = ($urandom_range(99) < 32'(ready_pct));
      if (cyc == 10) begin
        n_vec++;
        if ({busy, key_valid, done} !== 3'b100) begin
          $display("FAIL fwd_phase cyc=%0d busy/valid/done got=%b exp=100", cyc, {busy, key_valid, done});
          n_err++;
        end
      end
      if (key_valid) begin
        e = exp_q[0];
        n_vec++;
        if ({done, round_out, key_out} !== {1'b0, e}) begin
          $display("FAIL key_stream cyc=%0d got done=%b r=%0d k=%h exp done=0 r=%0d k=%h",
                   cyc, done, round_out, key_out, e[131:128], e[127:0]);
          n_err++;
        end
        if (key_ready) begin
          void'(exp_q.pop_front());
          if (ready_pct == 100) begin
            n_vec++;
            if (cyc != 21 - int'(e[131:128])) begin
              $display("FAIL key_timing round=%0d got cycle=%0d exp cycle=%0d", e[131:128], cyc, 21 - int'(e[131:128]));
              n_err++;
            end
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    key_ready = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      $display("FAIL job_timeout got %0d keys left exp 0", exp_q.size());
      n_err++;
      exp_q.delete();
    end else if ({done, key_valid, busy, state_dbg} !== 5'b10000) begin
      $display("FAIL done_pulse got done/valid/busy/state=%b exp=10000", {done, key_valid, busy, state_dbg});
      n_err++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    keyin = {4{32'hdeadbeef}};
    repeat (2) @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    n_vec++;
    if ({key_out, round_out, key_valid, busy, done, state_dbg} !== '0) begin
      $display("FAIL reset_values got k=%h r=%0d v=%b b=%b d=%b s=%0d exp all zero",
               key_out, round_out, key_valid, busy, done, state_dbg);
      n_err++;
    end
  endtask

  task automatic test_fips();
    key_ready = 1'b1;
    keyin = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_vec++;
    if ({key_valid, round_out, key_out} !== {1'b1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6}) begin
      $display("FAIL fips_r10 got v=%b r=%0d k=%h exp v=1 r=10 k=d014f9a8c9ee2589e13f0cc8b6630ca6", key_valid, round_out, key_out);
      n_err++;
    end
    @(negedge clk);
    n_vec++;
    if ({round_out, key_out} !== {4'd9, 128'hac7766f319fadc2128d12941575c006e}) begin
      $display("FAIL fips_r9 got r=%0d k=%h exp r=9 k=ac7766f319fadc2128d12941575c006e", round_out, key_out);
      n_err++;
    end
    repeat (8) @(negedge clk);
    n_vec++;
    if ({round_out, key_out} !== {4'd1, 128'ha0fafe1788542cb123a339392a6c7605}) begin
      $display("FAIL fips_r1 got r=%0d k=%h exp r=1 k=a0fafe1788542cb123a339392a6c7605", round_out, key_out);
      n_err++;
    end
    @(negedge clk);
    n_vec++;
    if ({key_valid, round_out, key_out} !== {1'b1, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c}) begin
      $display("FAIL fips_r0 got v=%b r=%0d k=%h exp v=1 r=0 k=2b7e151628aed2a6abf7158809cf4f3c", key_valid, round_out, key_out);
      n_err++;
    end
    @(negedge clk);
    n_vec++;
    if ({done, busy, key_valid} !== 3'b100) begin
      $display("FAIL fips_done got done/busy/valid=%b exp=100", {done, busy, key_valid});
      n_err++;
    end
    key_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      $display("FAIL done_width got done=%b exp=0", done);
      n_err++;
    end
  endtask

  task automatic test_zero_key();
    key_ready = 1'b1;
    keyin = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_vec++;
    if ({key_valid, round_out, key_out} !== {1'b1, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e}) begin
      $display("FAIL zero_first got v=%b r=%0d k=%h exp v=1 r=10 k=b4ef5bcb3e92e21123e951cf6f8f188e", key_valid, round_out, key_out);
      n_err++;
    end
    repeat (10) @(negedge clk);
    n_vec++;
    if ({key_valid, round_out, key_out} !== {1'b1, 4'd0, 128'h0}) begin
      $display("FAIL zero_last got v=%b r=%0d k=%h exp v=1 r=0 k=0", key_valid, round_out, key_out);
      n_err++;
    end
    @(negedge clk);
    key_ready = 1'b0;
    n_vec++;
    if (done !== 1'b1) begin
      $display("FAIL zero_done got done=%b exp=1", done);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    run_job({$urandom, $urandom, $urandom, $urandom}, 100, 1'b0);
    run_job({$urandom, $urandom, $urandom, $urandom}, 100, 1'b0);
    run_job(128'hffffffffffffffffffffffffffffffff, 100, 1'b0);
  endtask

  task automatic test_start_ignored();
    for (int n = 0; n < 20; n++)
      run_job({$urandom, $urandom, $urandom, $urandom}, 50, 1'b1);
  endtask

  task automatic test_reset_mid();
    key_ready = 1'b0;
    keyin = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({key_out, round_out, key_valid, busy, done, state_dbg} !== '0) begin
      $display("FAIL reset_fwd got k=%h r=%0d v=%b b=%b d=%b s=%0d exp all zero",
               key_out, round_out, key_valid, busy, done, state_dbg);
      n_err++;
    end
    keyin = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({key_out, round_out, key_valid, busy, done, state_dbg} !== '0) begin
      $display("FAIL reset_emit got k=%h r=%0d v=%b b=%b d=%b s=%0d exp all zero",
               key_out, round_out, key_valid, busy, done, state_dbg);
      n_err++;
    end
    @(negedge clk);
    n_vec++;
    if ({done, busy, state_dbg} !== 4'b0000) begin
      $display("FAIL reset_no_done got done/busy/state=%b exp=0000", {done, busy, state_dbg});
      n_err++;
    end
    run_job({$urandom, $urandom, $urandom, $urandom}, 100, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 1000; n++)
      run_job({$urandom, $urandom, $urandom, $urandom}, 50, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    key_ready = 1'b0;
    keyin = '0;
    build_sbox();
    test_reset();
    test_fips();
    test_zero_key();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Sequential AES-128 key scheduler that delivers round keys in reverse order (round 10 down to round 0) for the decryption datapath, which consumes them alongside `inverse_shift_Rows`. It accepts the cipher key and runs the forward expansion for 10 cycles to reach the round-10 key. It then walks the schedule backwards one key per handshake, so only one 128-bit key register is kept instead of the full 1408-bit expanded array.

## Interface
- No parameters; fixed AES-128 (10 rounds, 4 words per key).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge.
- `start`  in  1  request; accepted only in IDLE.
- `keyin`  in  128  cipher key (round-0 key), sampled on the accepting edge; `w0`=[127:96] … `w3`=[31:0].
- `key_out`  out  128  current round key, same word packing as `keyin`.
- `round_out`  out  4  round index of `key_out` (10..0).
- `key_valid`  out  1  `key_out`/`round_out` valid.
- `key_ready`  in  1  consumer accepts; handshake = `key_valid & key_ready`.
- `busy`  out  1  high in FWD and EMIT.
- `done`  out  1  one-cycle pulse after round-0 key is accepted.

## Operation
- Reset values: `key_out`=0, `round_out`=0, `key_valid`=0, `busy`=0, `done`=0; state IDLE, step counter 0.
- SubWord(x) = forward S-box on each byte of x. RotWord(x) = {x[23:0],x[31:24]}. rcon(j) for j=0..9 = 01,02,04,08,10,20,40,80,1b,36 in bits [31:24], zero elsewhere.
- Forward step with index j: w0'=w0^SubWord(RotWord(w3))^rcon(j); w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- Inverse step from round r to round r-1: w3=w3'^w2'; w2=w2'^w1'; w1=w1'^w0'; w0=w0'^SubWord(RotWord(w3))^rcon(r-1).
- Exactly one 4-byte SubWord instance is used. Its input is muxed: current `w3` in FWD, recovered `w3'^w2'` in EMIT.
- FSM:
  - IDLE: `start`=1 loads `keyin` into the key register, clears the counter and goes to FWD.
  - FWD: applies one forward step per cycle with j = counter, then increments the counter. After the step with j=9, it loads `round_out`=10 and goes to EMIT.
  - EMIT: `key_valid`=1. On handshake with `round_out`>0, it applies the inverse step and decrements `round_out`. On handshake with `round_out`=0, it sets `done` for one cycle, clears `key_valid`, and goes to IDLE.
- Without a handshake, `key_out`/`round_out` are held stable while `key_valid`=1.
- `start` is ignored outside IDLE, including during EMIT stalls.
- `reset` mid-operation aborts immediately to IDLE with reset values; no `done` pulse.
- `key_ready` outside EMIT has no effect.
- `key_out` outside EMIT reflects the internal register (intermediate forward keys); the consumer must gate on `key_valid`.

## Timing
- Cycle 0: `start` high in IDLE. Cycles 1–10: FWD, `busy`=1.
- Cycle 11: `key_valid`=1, `round_out`=10, `key_out`=round-10 key.
- With `key_ready` held high, one key per cycle: round r appears at cycle 21-r, round 0 at cycle 21.
- Cycle 22: `done`=1, `busy`=0, `key_valid`=0, state IDLE.
- `start` in cycle 22 is accepted, giving back-to-back jobs every 22 cycles.
- Every stall cycle with `key_ready`=0 adds one cycle of latency.
- Inverse step is single-cycle combinational: S-box plus XOR chain between registers.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `key_ready`=1 → cycle 11 `key_out`=d014f9a8c9ee2589e13f0cc8b6630ca6 (`round_out`=10). Cycle 12 ac7766f319fadc2128d12941575c006e (9). Cycle 20 a0fafe1788542cb123a339392a6c7605 (1). Cycle 21 2b7e1516… (0). `done` pulse at cycle 22.
- All-zero key → first emitted key b4ef5bcb3e92e21123e951cf6f8f188e. Last emitted key 0.
- Backpressure: `key_ready` random 50% → the 11 keys arrive in order 10..0, unchanged during stalls, `done` only after the round-0 handshake. Compare against a software model for 1000 random keys.
- `start` pulsed during FWD and during an EMIT stall → ignored; the sequence is unaffected. `start` coincident with `done` → the new job begins, with its first key at +11 cycles.
- `reset` asserted at cycle 5 (FWD) and at an EMIT cycle → next cycle all outputs are 0 and state is IDLE. A fresh `start` then produces correct keys.
